// File: rtl/frame_buffer_dbuf.sv
// Double-buffered RGB frame store: raster writes into the back bank, row-pair reads from the front bank.
// Read latency 1 cycle; wr_ready drops once a full frame waits for the scanner's frame_start swap.
module frame_buffer_dbuf #(
   parameter int WIDTH      = 64,
   parameter int HEIGHT     = 64,
   parameter int COLOR_BITS = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [3*COLOR_BITS-1:0]       wr_data,
   input  logic                          wr_last,
   input  logic                          frame_start,
   input  logic                          rd_en,
   input  logic [$clog2(WIDTH)-1:0]      rd_x,
   input  logic [$clog2(HEIGHT/2)-1:0]   rd_row,
   output logic [3*COLOR_BITS-1:0]       rd_top,
   output logic [3*COLOR_BITS-1:0]       rd_bot,
   output logic                          rd_valid,
   output logic                          swap_done,
   output logic                          frame_err
);

   localparam int XW    = $clog2(WIDTH);
   localparam int YW    = $clog2(HEIGHT);
   localparam int RW    = YW - 1;
   localparam int AW    = XW + RW;
   localparam int PW    = 3 * COLOR_BITS;
   localparam int DEPTH = WIDTH * HEIGHT / 2;

   typedef enum logic {S_FILL, S_WAIT_SWAP} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_front;
   logic [XW-1:0]   r_wr_x;
   logic [YW-1:0]   r_wr_y;
   logic            r_swap_done;
   logic            r_frame_err;
   logic [PW-1:0]   r_rd_top;
   logic [PW-1:0]   r_rd_bot;
   logic            r_rd_valid;

   logic [PW-1:0]   r_mem_0t [DEPTH];
   logic [PW-1:0]   r_mem_0b [DEPTH];
   logic [PW-1:0]   r_mem_1t [DEPTH];
   logic [PW-1:0]   r_mem_1b [DEPTH];

   logic            w_wr_fire;
   logic            w_last_pix;
   logic            w_swap;
   logic            w_wr_bot;
   logic [AW-1:0]   w_wr_addr;
   logic [AW-1:0]   w_rd_addr;

   assign wr_ready   = rst_n && (r_state == S_FILL);
   assign w_wr_fire  = wr_valid && wr_ready;
   assign w_last_pix = (r_wr_x == XW'(WIDTH - 1)) && (r_wr_y == YW'(HEIGHT - 1));
   assign w_swap     = (r_state == S_WAIT_SWAP) && frame_start;
   assign w_wr_bot   = r_wr_y[YW-1];
   assign w_wr_addr  = {r_wr_y[RW-1:0], r_wr_x};
   assign w_rd_addr  = {rd_row, rd_x};

   assign swap_done  = r_swap_done;
   assign frame_err  = r_frame_err;
   assign rd_top     = r_rd_top;
   assign rd_bot     = r_rd_bot;
   assign rd_valid   = r_rd_valid;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FILL:      if (w_wr_fire && w_last_pix) w_state_nxt = S_WAIT_SWAP;
         S_WAIT_SWAP: if (frame_start)             w_state_nxt = S_FILL;
         default:                                  w_state_nxt = S_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_FILL;
         r_front     <= 1'b0;
         r_wr_x      <= '0;
         r_wr_y      <= '0;
         r_swap_done <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_swap_done <= w_swap;
         if (w_swap) begin
            r_front <= ~r_front;
            r_wr_x  <= '0;
            r_wr_y  <= '0;
         end else if (w_wr_fire) begin
            // An early wr_last abandons the partial frame and restarts at the origin.
            if (wr_last && !w_last_pix) begin
               r_frame_err <= 1'b1;
               r_wr_x      <= '0;
               r_wr_y      <= '0;
            end else begin
               if (w_last_pix && !wr_last) r_frame_err <= 1'b1;
               r_wr_x <= r_wr_x + XW'(1);
               if (r_wr_x == XW'(WIDTH - 1)) r_wr_y <= r_wr_y + YW'(1);
            end
         end
      end
   end

   // Writes always land in the back bank (~r_front); RAM contents are never reset.
   always_ff @(posedge clk) begin
      if (w_wr_fire) begin
         if (r_front) begin
            if (w_wr_bot) r_mem_0b[w_wr_addr] <= wr_data;
            else          r_mem_0t[w_wr_addr] <= wr_data;
         end else begin
            if (w_wr_bot) r_mem_1b[w_wr_addr] <= wr_data;
            else          r_mem_1t[w_wr_addr] <= wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_top   <= '0;
         r_rd_bot   <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= rd_en;
         if (rd_en) begin
            r_rd_top <= r_front ? r_mem_1t[w_rd_addr] : r_mem_0t[w_rd_addr];
            r_rd_bot <= r_front ? r_mem_1b[w_rd_addr] : r_mem_0b[w_rd_addr];
         end
      end
   end

endmodule

// File: tb/tb_frame_buffer_dbuf.sv
// Directed bench for frame_buffer_dbuf: frames tagged with k in bits [11:6], x^y in bits [5:0].
module tb_frame_buffer_dbuf;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid;
   logic        wr_ready;
   logic [11:0] wr_data;
   logic        wr_last;
   logic        frame_start;
   logic        rd_en;
   logic [5:0]  rd_x;
   logic [4:0]  rd_row;
   logic [11:0] rd_top;
   logic [11:0] rd_bot;
   logic        rd_valid;
   logic        swap_done;
   logic        frame_err;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   frame_buffer_dbuf #(.WIDTH(64), .HEIGHT(64), .COLOR_BITS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
      .frame_start(frame_start),
      .rd_en(rd_en), .rd_x(rd_x), .rd_row(rd_row),
      .rd_top(rd_top), .rd_bot(rd_bot), .rd_valid(rd_valid),
      .swap_done(swap_done), .frame_err(frame_err)
   );

   function automatic logic [11:0] pix(input int k, input int x, input int y);
      return 12'((k << 6) | ((x ^ y) & 63));
   endfunction

   // Streams pixels 0..count-1 of frame k starting at (0,0); optional frame_start on the final one.
   task automatic stream(input int k, input int count, input int last_idx, input bit fs_on_last);
      bit stall = 1'b0;
      for (int i = 0; i < count; i++) begin
         wr_valid    = 1'b1;
         wr_data     = pix(k, i % 64, (i / 64) % 64);
         wr_last     = (i == last_idx);
         frame_start = fs_on_last && (i == count - 1);
         #1;
         if (!wr_ready) stall = 1'b1;
         @(negedge clk);
      end
      wr_valid    = 1'b0;
      wr_last     = 1'b0;
      frame_start = 1'b0;
      n_total++;
      if (stall) $display("FAIL stream_ready k=%0d: wr_ready saw 0, required 1", k);
      else n_pass++;
   endtask

   task automatic do_read(input int x, input int row);
      rd_en  = 1'b1;
      rd_x   = 6'(x);
      rd_row = 5'(row);
      @(negedge clk);
      rd_en  = 1'b0;
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wr_valid = 0; wr_data = '0; wr_last = 0; frame_start = 0;
      rd_en = 0; rd_x = '0; rd_row = '0;
      repeat (3) @(negedge clk);
      n_total++;
      if ({wr_ready, rd_valid, swap_done, frame_err} !== 4'b0000)
         $display("FAIL reset_flags: got %b, required 0000", {wr_ready, rd_valid, swap_done, frame_err});
      else n_pass++;
      n_total++;
      if (rd_top !== 12'd0 || rd_bot !== 12'd0)
         $display("FAIL reset_rd_data: got top=%0d bot=%0d, required 0 0", rd_top, rd_bot);
      else n_pass++;
      rst_n = 1'b1;
      #1;
      n_total++;
      if (wr_ready !== 1'b1) $display("FAIL post_reset_ready: got %b, required 1", wr_ready);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_fill_swap_read();
      stream(0, 4096, 4095, 1'b0);
      // Writer keeps offering a pixel while the full frame waits for the scanner.
      wr_valid = 1'b1;
      wr_data  = 12'hABC;
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if (wr_ready !== 1'b0) $display("FAIL wait_swap_ready cyc%0d: got %b, required 0", i, wr_ready);
         else n_pass++;
         @(negedge clk);
      end
      n_total++;
      if (frame_err !== 1'b0) $display("FAIL good_frame_err: got %b, required 0", frame_err);
      else n_pass++;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      n_total++;
      if (swap_done !== 1'b1 || wr_ready !== 1'b1)
         $display("FAIL swap_pulse: got swap_done=%b wr_ready=%b, required 1 1", swap_done, wr_ready);
      else n_pass++;
      wr_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if (swap_done !== 1'b0) $display("FAIL swap_pulse_width: got %b, required 0", swap_done);
      else n_pass++;
      do_read(5, 3);
      n_total++;
      if (rd_valid !== 1'b1 || rd_top !== 12'd6 || rd_bot !== 12'd38)
         $display("FAIL read_5_3: got v=%b top=%0d bot=%0d, required 1 6 38", rd_valid, rd_top, rd_bot);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (rd_valid !== 1'b0 || rd_top !== 12'd6)
         $display("FAIL read_hold: got v=%b top=%0d, required 0 6", rd_valid, rd_top);
      else n_pass++;
   endtask

   task automatic test_partial_frame();
      stream(1, 101, 100, 1'b0);
      n_total++;
      if (frame_err !== 1'b1 || wr_ready !== 1'b1)
         $display("FAIL partial_err: got err=%b ready=%b, required 1 1", frame_err, wr_ready);
      else n_pass++;
      stream(2, 4096, 4095, 1'b0);
      n_total++;
      if (wr_ready !== 1'b0) $display("FAIL partial_then_full_ready: got %b, required 0", wr_ready);
      else n_pass++;
      do_read(63, 31);
      n_total++;
      if (rd_top !== pix(0, 63, 31) || rd_bot !== pix(0, 63, 63))
         $display("FAIL old_front_read: got top=%0d bot=%0d, required %0d %0d",
                  rd_top, rd_bot, pix(0, 63, 31), pix(0, 63, 63));
      else n_pass++;
      pulse_fs();
      n_total++;
      if (swap_done !== 1'b1) $display("FAIL partial_swap: got %b, required 1", swap_done);
      else n_pass++;
      do_read(5, 3);
      n_total++;
      if (rd_top !== 12'd134 || rd_bot !== 12'd166 || frame_err !== 1'b1)
         $display("FAIL new_front_read: got top=%0d bot=%0d err=%b, required 134 166 1", rd_top, rd_bot, frame_err);
      else n_pass++;
   endtask

   task automatic test_coincident_swap();
      pulse_fs();
      n_total++;
      if (swap_done !== 1'b0) $display("FAIL fs_in_fill: got swap_done=%b, required 0", swap_done);
      else n_pass++;
      stream(3, 4096, 4095, 1'b1);
      n_total++;
      if (swap_done !== 1'b0 || wr_ready !== 1'b0)
         $display("FAIL coincident_no_swap: got swap_done=%b ready=%b, required 0 0", swap_done, wr_ready);
      else n_pass++;
      do_read(5, 3);
      n_total++;
      if (rd_top !== 12'd134) $display("FAIL coincident_old_data: got %0d, required 134", rd_top);
      else n_pass++;
      pulse_fs();
      n_total++;
      if (swap_done !== 1'b1) $display("FAIL coincident_late_swap: got %b, required 1", swap_done);
      else n_pass++;
      do_read(5, 3);
      n_total++;
      if (rd_top !== 12'd198 || rd_bot !== 12'd230)
         $display("FAIL coincident_new_data: got top=%0d bot=%0d, required 198 230", rd_top, rd_bot);
      else n_pass++;
   endtask

   task automatic test_back_to_back_swap_read();
      stream(4, 4096, 4095, 1'b0);
      rd_en = 1'b1; rd_x = 6'd5; rd_row = 5'd3;
      @(negedge clk);
      n_total++;
      if (rd_valid !== 1'b1 || rd_top !== 12'd198)
         $display("FAIL b2b_first: got v=%b top=%0d, required 1 198", rd_valid, rd_top);
      else n_pass++;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      n_total++;
      if (rd_valid !== 1'b1 || rd_top !== 12'd198 || swap_done !== 1'b1)
         $display("FAIL b2b_fs_cycle: got v=%b top=%0d swap=%b, required 1 198 1", rd_valid, rd_top, swap_done);
      else n_pass++;
      @(negedge clk);
      rd_en = 1'b0;
      n_total++;
      if (rd_valid !== 1'b1 || rd_top !== 12'd262 || rd_bot !== 12'd294)
         $display("FAIL b2b_after_swap: got v=%b top=%0d bot=%0d, required 1 262 294", rd_valid, rd_top, rd_bot);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (rd_valid !== 1'b0) $display("FAIL b2b_valid_drop: got %b, required 0", rd_valid);
      else n_pass++;
   endtask

   task automatic test_midframe_reset();
      stream(5, 2000, -1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({wr_ready, rd_valid, swap_done, frame_err} !== 4'b0000 || rd_top !== 12'd0 || rd_bot !== 12'd0)
         $display("FAIL async_reset: got flags=%b top=%0d bot=%0d, required 0000 0 0",
                  {wr_ready, rd_valid, swap_done, frame_err}, rd_top, rd_bot);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      stream(6, 4096, 4095, 1'b0);
      pulse_fs();
      n_total++;
      if (swap_done !== 1'b1 || frame_err !== 1'b0)
         $display("FAIL restart_swap: got swap=%b err=%b, required 1 0", swap_done, frame_err);
      else n_pass++;
      do_read(0, 0);
      n_total++;
      if (rd_top !== 12'd384 || rd_bot !== 12'd416)
         $display("FAIL restart_origin: got top=%0d bot=%0d, required 384 416", rd_top, rd_bot);
      else n_pass++;
      do_read(5, 3);
      n_total++;
      if (rd_top !== 12'd390 || rd_bot !== 12'd422)
         $display("FAIL restart_5_3: got top=%0d bot=%0d, required 390 422", rd_top, rd_bot);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_fill_swap_read();
      test_partial_frame();
      test_coincident_swap();
      test_back_to_back_swap_read();
      test_midframe_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
